// File: rtl/buffer5x5.sv
// rtl/buffer5x5.sv - 5x5 sliding pixel window with right/left/down shifts; optional clear port via BUFFER5X5_CLEAR_EN
module buffer5x5 #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  n_rst,
`ifdef BUFFER5X5_CLEAR_EN
   input  logic                  clear,
`endif
   input  logic                  shift_enable,
   input  logic [1:0]            shift_direction,
   input  logic [DATA_WIDTH-1:0] buffer_input  [0:4],
   output logic [DATA_WIDTH-1:0] buffer_output [0:4][0:4]
);

   localparam logic [1:0] DIR_HOLD  = 2'b00;
   localparam logic [1:0] DIR_RIGHT = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_DOWN  = 2'b11;

   // Next window contents; the output registers are the window itself, so
   // there is no combinational path from the inputs to buffer_output.
   logic [DATA_WIDTH-1:0] w_next [0:4][0:4];

   // Select the shifted window for the current direction; hold otherwise.
   always_comb begin
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 5; c++) begin
            w_next[r][c] = buffer_output[r][c];
         end
      end
      if (shift_enable) begin
         case (shift_direction)
            DIR_RIGHT: begin
               for (int r = 0; r < 5; r++) begin
                  w_next[r][0] = buffer_input[r];
                  for (int c = 1; c < 5; c++) begin
                     w_next[r][c] = buffer_output[r][c-1];
                  end
               end
            end
            DIR_LEFT: begin
               for (int r = 0; r < 5; r++) begin
                  w_next[r][4] = buffer_input[r];
                  for (int c = 0; c < 4; c++) begin
                     w_next[r][c] = buffer_output[r][c+1];
                  end
               end
            end
            DIR_DOWN: begin
               for (int c = 0; c < 5; c++) begin
                  w_next[0][c] = buffer_input[c];
                  for (int r = 1; r < 5; r++) begin
                     w_next[r][c] = buffer_output[r-1][c];
                  end
               end
            end
            DIR_HOLD: ;
            default: ;
         endcase
      end
   end

   // Window registers: reset (and optional clear) wipe everything, else load next.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
               buffer_output[r][c] <= '0;
            end
         end
      end
`ifdef BUFFER5X5_CLEAR_EN
      else if (clear) begin
         for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
               buffer_output[r][c] <= '0;
            end
         end
      end
`endif
      else begin
         for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
               buffer_output[r][c] <= w_next[r][c];
            end
         end
      end
   end

endmodule

// File: tb/tb_buffer5x5.sv
// tb/tb_buffer5x5.sv - directed and randomized checks of buffer5x5 against a window model
module tb_buffer5x5;

   localparam int DW = 8;

   logic          tb_clk = 1'b0;
   logic          n_rst;
   logic          clear;
   logic          shift_enable;
   logic [1:0]    shift_direction;
   logic [DW-1:0] buffer_input  [0:4];
   logic [DW-1:0] buffer_output [0:4][0:4];

   int checks = 0;
   int errors = 0;

   // reference window, kept as plain integers
   int model [5][5];

   always #5 tb_clk = ~tb_clk;

   buffer5x5 #(.DATA_WIDTH(DW)) dut (
      .clk             (tb_clk),
      .n_rst           (n_rst),
`ifdef BUFFER5X5_CLEAR_EN
      .clear           (clear),
`endif
      .shift_enable    (shift_enable),
      .shift_direction (shift_direction),
      .buffer_input    (buffer_input),
      .buffer_output   (buffer_output)
   );

   task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [199:0] dut_window();
      logic [199:0] v;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            v[(r*5+c)*8 +: 8] = buffer_output[r][c];
      return v;
   endfunction

   function automatic logic [199:0] model_window();
      logic [199:0] v;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            v[(r*5+c)*8 +: 8] = model[r][c][7:0];
      return v;
   endfunction

   // pattern: 0 zero, 1 right-fill (5-c), 2 down-fill (5-r), 3 left-fill (c+1), 4 right+1 (6-c)
   function automatic logic [199:0] pattern(input int kind);
      logic [199:0] v;
      int val;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) begin
            case (kind)
               1: val = 5 - c;
               2: val = 5 - r;
               3: val = c + 1;
               4: val = 6 - c;
               default: val = 0;
            endcase
            v[(r*5+c)*8 +: 8] = val[7:0];
         end
      return v;
   endfunction

   // Window after one edge, derived from the shift rules on whole rows/columns.
   task automatic model_step(input logic rst, input logic en, input logic [1:0] dir, input int in_vals [5]);
      int old [5][5];
      old = model;
      if (!rst) begin
         for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) model[r][c] = 0;
      end else if (en) begin
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
               case (dir)
                  2'b01: model[r][c] = (c == 0) ? in_vals[r] : old[r][c-1];
                  2'b10: model[r][c] = (c == 4) ? in_vals[r] : old[r][c+1];
                  2'b11: model[r][c] = (r == 0) ? in_vals[c] : old[r-1][c];
                  default: model[r][c] = old[r][c];
               endcase
            end
      end
   endtask

   task automatic step(input logic rst, input logic en, input logic [1:0] dir, input int in_vals [5]);
      @(negedge tb_clk);
      n_rst           = rst;
      shift_enable    = en;
      shift_direction = dir;
      for (int i = 0; i < 5; i++) buffer_input[i] = in_vals[i][7:0];
      @(posedge tb_clk);
      #1;
      model_step(rst, en, dir, in_vals);
   endtask

   task automatic step_all(input logic rst, input logic en, input logic [1:0] dir, input int val);
      int v [5];
      for (int i = 0; i < 5; i++) v[i] = val;
      step(rst, en, dir, v);
   endtask

   initial begin
      int v [5];
      clear = 1'b0;
      for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) model[r][c] = 0;

      step_all(1'b0, 1'b0, 2'b00, 0);
      check("reset", dut_window(), pattern(0));

      // hold when disabled
      step_all(1'b1, 1'b0, 2'b01, 'hF1);
      step_all(1'b1, 1'b0, 2'b11, 'hF1);
      check("hold_disabled", dut_window(), pattern(0));

      // direction 00 holds
      step_all(1'b1, 1'b1, 2'b00, 'hF1);
      step_all(1'b1, 1'b1, 2'b00, 'hF1);
      check("hold_dir00", dut_window(), pattern(0));

      // shift right fill
      step_all(1'b0, 1'b0, 2'b00, 0);
      for (int k = 1; k <= 5; k++) step_all(1'b1, 1'b1, 2'b01, k);
      check("right_fill", dut_window(), pattern(1));
      step_all(1'b1, 1'b1, 2'b01, 6);
      check("right_extra", dut_window(), pattern(4));

      // shift down fill
      step_all(1'b0, 1'b0, 2'b00, 0);
      for (int k = 1; k <= 5; k++) step_all(1'b1, 1'b1, 2'b11, k);
      check("down_fill", dut_window(), pattern(2));

      // shift left fill
      step_all(1'b0, 1'b0, 2'b00, 0);
      for (int k = 1; k <= 5; k++) step_all(1'b1, 1'b1, 2'b10, k);
      check("left_fill", dut_window(), pattern(3));

      // latency: first right shift shows only column 0 one edge later
      step_all(1'b0, 1'b0, 2'b00, 0);
      step_all(1'b1, 1'b1, 2'b01, 'h3C);
      check("right_first", dut_window(), model_window());
      check("right_first_c0", {192'd0, buffer_output[2][0]}, 200'h3C);

      // reset mid-operation discards window and the input on that edge
      step_all(1'b0, 1'b0, 2'b00, 0);
      for (int k = 1; k <= 3; k++) step_all(1'b1, 1'b1, 2'b01, k);
      check("partial_fill", dut_window(), model_window());
      step_all(1'b0, 1'b1, 2'b01, 'hAA);
      check("mid_reset", dut_window(), pattern(0));

      // down shift with distinct per-column values
      v = '{'h11, 'h22, 'h33, 'h44, 'h55};
      step(1'b1, 1'b1, 2'b11, v);
      check("down_cols", {192'd0, buffer_output[0][3]}, 200'h44);
      check("down_row", dut_window(), model_window());

      // randomized mix of directions, enables and occasional resets
      for (int n = 0; n < 400; n++) begin
         logic rst;
         rst = ($urandom_range(0, 19) != 0);
         for (int i = 0; i < 5; i++) v[i] = $urandom_range(0, 255);
         step(rst, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), v);
         check($sformatf("rand%0d", n), dut_window(), model_window());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
